// File: rtl/sru_pkg.sv
// Shared op encodings and FSM state type for the shift/rotate unit and Mini_SRC decode.
package sru_pkg;

  localparam logic [2:0] OP_SHR  = 3'b000;
  localparam logic [2:0] OP_SHL  = 3'b001;
  localparam logic [2:0] OP_ROR  = 3'b010;
  localparam logic [2:0] OP_ROL  = 3'b011;
  localparam logic [2:0] OP_SHRA = 3'b100;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_DONE = 2'b10
  } state_t;

endpackage

// File: rtl/sru_step.sv
// Combinational single-step shifter/rotator: moves i_x by i_k (0..STEP) positions.
// Sign-fill input exists only when SHIFT_ROTATE_SHRA_EN is defined.
module sru_step
  import sru_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int STEP  = 1,
  localparam int KW   = $clog2(STEP + 1)
) (
  input  logic [WIDTH-1:0] i_x,
  input  logic [2:0]       i_op,
`ifdef SHIFT_ROTATE_SHRA_EN
  input  logic             i_fill,
`endif
  input  logic [KW-1:0]    i_k,
  output logic [WIDTH-1:0] o_y
);

  logic [2*WIDTH-1:0] w_dbl;

  // Rotates and sign fill are done on a double-width word so one shifter covers all cases.
  always_comb begin
    w_dbl = '0;
    o_y   = i_x;
    case (i_op)
      OP_SHR: o_y = i_x >> i_k;
      OP_SHL: o_y = i_x << i_k;
      OP_ROR: begin
        w_dbl = {i_x, i_x} >> i_k;
        o_y   = w_dbl[WIDTH-1:0];
      end
      OP_ROL: begin
        w_dbl = {i_x, i_x} << i_k;
        o_y   = w_dbl[2*WIDTH-1:WIDTH];
      end
`ifdef SHIFT_ROTATE_SHRA_EN
      OP_SHRA: begin
        w_dbl = {{WIDTH{i_fill}}, i_x} >> i_k;
        o_y   = w_dbl[WIDTH-1:0];
      end
`endif
      default: o_y = i_x;
    endcase
  end

endmodule

// File: rtl/shift_rotate_unit.sv
// Multi-cycle shift/rotate unit with start/done handshake, up to STEP bits per RUN cycle.
// Define SHIFT_ROTATE_SHRA_EN to build arithmetic shift right (op 100).
module shift_rotate_unit
  import sru_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int STEP  = 1
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] amount,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int LW = $clog2(WIDTH);
  localparam int CW = LW + 1;
  localparam int KW = $clog2(STEP + 1);
  localparam logic [WIDTH-1:0] AMT_MAX  = WIDTH'(WIDTH);
  localparam logic [CW-1:0]    CNT_FULL = CW'(WIDTH);
  localparam logic [CW-1:0]    STEP_C   = CW'(STEP);

  state_t           r_state;
  logic [2:0]       r_op;
  logic [CW-1:0]    r_count;
  logic [WIDTH-1:0] r_result;
`ifdef SHIFT_ROTATE_SHRA_EN
  logic             r_sign;
`endif

  logic [CW-1:0]    w_shift_n;
  logic [CW-1:0]    w_n;
  logic [CW-1:0]    w_k;
  logic [WIDTH-1:0] w_step;

  // Shifts saturate at WIDTH on the full amount; rotates only need amount mod WIDTH.
  assign w_shift_n = (amount >= AMT_MAX) ? CNT_FULL : CW'(amount);

  always_comb begin
    w_n = '0;
    case (op)
      OP_SHR, OP_SHL: w_n = w_shift_n;
      OP_ROR, OP_ROL: w_n = CW'(amount[LW-1:0]);
`ifdef SHIFT_ROTATE_SHRA_EN
      OP_SHRA:        w_n = w_shift_n;
`endif
      default:        w_n = '0;
    endcase
  end

  assign w_k = (r_count < STEP_C) ? r_count : STEP_C;

  sru_step #(
    .WIDTH (WIDTH),
    .STEP  (STEP)
  ) u_step (
    .i_x    (r_result),
    .i_op   (r_op),
`ifdef SHIFT_ROTATE_SHRA_EN
    .i_fill (r_sign),
`endif
    .i_k    (KW'(w_k)),
    .o_y    (w_step)
  );

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      r_state  <= S_IDLE;
      r_op     <= OP_SHR;
      r_count  <= '0;
      r_result <= '0;
`ifdef SHIFT_ROTATE_SHRA_EN
      r_sign   <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_result <= a;
            r_op     <= op;
            r_count  <= w_n;
`ifdef SHIFT_ROTATE_SHRA_EN
            r_sign   <= a[WIDTH-1];
`endif
            r_state  <= (w_n != '0) ? S_RUN : S_DONE;
          end else begin
            r_state  <= S_IDLE;
          end
        end
        S_RUN: begin
          r_result <= w_step;
          r_count  <= r_count - w_k;
          if (r_count == w_k) r_state <= S_DONE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy   = (r_state == S_RUN);
  assign done   = (r_state == S_DONE);
  assign result = r_result;

endmodule

// File: tb/tb_shift_rotate_unit.sv
// Directed bench: one STEP=1 and one STEP=8 instance driven by the same inputs.
module tb_shift_rotate_unit;
  import sru_pkg::*;

  logic        clk = 1'b0;
  logic        clr_n;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a, amount;
  logic        busy1, done1, busy8, done8;
  logic [31:0] res1, res8;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  shift_rotate_unit #(.WIDTH(32), .STEP(1)) dut1 (
    .clk(clk), .clr_n(clr_n), .start(start), .op(op), .a(a), .amount(amount),
    .busy(busy1), .done(done1), .result(res1)
  );

  shift_rotate_unit #(.WIDTH(32), .STEP(8)) dut8 (
    .clk(clk), .clr_n(clr_n), .start(start), .op(op), .a(a), .amount(amount),
    .busy(busy8), .done(done8), .result(res8)
  );

  typedef struct {
    string       name;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] amt;
    logic [31:0] res;
    int          l1;
    int          l8;
  } vec_t;

  vec_t vecs[16];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  // Called at a negedge; start is sampled at the next posedge (E0).
  task automatic launch(input logic [2:0] f_op, input logic [31:0] f_a, input logic [31:0] f_amt);
    start = 1'b1; op = f_op; a = f_a; amount = f_amt;
    @(posedge clk); #1;
    start = 1'b0; op = 3'($urandom_range(0, 7)); a = $urandom; amount = $urandom;
  endtask

  // t counts negedges after E0; done seen at t means latency ceil(n/STEP) = t.
  task automatic watch(input string nm, input logic [31:0] er, input int l1, input int l8, input bit pulse);
    int c1 = -1;
    int c8 = -1;
    int d1 = 0;
    int d8 = 0;
    for (int t = 0; t < 40; t++) begin
      @(negedge clk);
      if (done1) begin
        d1++;
        if (c1 < 0) begin c1 = t; chk({nm, " res1"}, res1, er); end
        chk({nm, " busy1&done1"}, {31'd0, busy1}, 32'd0);
      end
      if (done8) begin
        d8++;
        if (c8 < 0) begin c8 = t; chk({nm, " res8"}, res8, er); end
        chk({nm, " busy8&done8"}, {31'd0, busy8}, 32'd0);
      end
      if (pulse && t == 0) begin start = 1'b1; op = OP_SHL; a = '0; amount = '0; end
      if (pulse && t == 1) start = 1'b0;
    end
    chk({nm, " lat1"}, c1, l1);
    chk({nm, " lat8"}, c8, l8);
    chk({nm, " ndone1"}, d1, 1);
    chk({nm, " ndone8"}, d8, 1);
    chk({nm, " hold1"}, res1, er);
    chk({nm, " hold8"}, res8, er);
  endtask

  initial begin
    vecs[0]  = '{"ror4",    OP_ROR, 32'h0000_00F1, 32'd4,        32'h1000_000F, 4, 1};
    vecs[1]  = '{"ror36",   OP_ROR, 32'h0000_00F1, 32'd36,       32'h1000_000F, 4, 1};
    vecs[2]  = '{"rol12",   OP_ROL, 32'h8000_0001, 32'd12,       32'h0000_1800, 12, 2};
    vecs[3]  = '{"shl0",    OP_SHL, 32'h1234_5678, 32'd0,        32'h1234_5678, 0, 0};
    vecs[4]  = '{"shr256",  OP_SHR, 32'hFFFF_FFFF, 32'h0000_0100, 32'h0000_0000, 32, 4};
`ifdef SHIFT_ROTATE_SHRA_EN
    vecs[5]  = '{"shra4",   OP_SHRA, 32'h8000_0010, 32'd4,       32'hF800_0001, 4, 1};
    vecs[13] = '{"shra40",  OP_SHRA, 32'h7000_0000, 32'd40,      32'h0000_0000, 32, 4};
    vecs[14] = '{"shra100", OP_SHRA, 32'h8000_0000, 32'd100,     32'hFFFF_FFFF, 32, 4};
`else
    vecs[5]  = '{"shra4",   OP_SHRA, 32'h8000_0010, 32'd4,       32'h8000_0010, 0, 0};
    vecs[13] = '{"shra40",  OP_SHRA, 32'h7000_0000, 32'd40,      32'h7000_0000, 0, 0};
    vecs[14] = '{"shra100", OP_SHRA, 32'h8000_0000, 32'd100,     32'h8000_0000, 0, 0};
`endif
    vecs[6]  = '{"shl8",    OP_SHL, 32'h0000_00FF, 32'd8,        32'h0000_FF00, 8, 1};
    vecs[7]  = '{"shr31",   OP_SHR, 32'h8000_0000, 32'd31,       32'h0000_0001, 31, 4};
    vecs[8]  = '{"ror32",   OP_ROR, 32'h1234_5678, 32'd32,       32'h1234_5678, 0, 0};
    vecs[9]  = '{"illegal", 3'b111, 32'hDEAD_BEEF, 32'd5,        32'hDEAD_BEEF, 0, 0};
    vecs[10] = '{"shlmax",  OP_SHL, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0000, 32, 4};
    vecs[11] = '{"rol4",    OP_ROL, 32'h1234_5678, 32'd4,        32'h2345_6781, 4, 1};
    vecs[12] = '{"shr3",    OP_SHR, 32'hF000_0000, 32'd3,        32'h1E00_0000, 3, 1};
    vecs[15] = '{"ror9",    OP_ROR, 32'h0000_0001, 32'd9,        32'h0080_0000, 9, 2};

    clr_n = 1'b0; start = 1'b0; op = '0; a = '0; amount = '0;
    repeat (2) @(negedge clk);
    chk("rst result1", res1, 32'd0);
    chk("rst result8", res8, 32'd0);
    chk("rst busy1", {31'd0, busy1}, 32'd0);
    chk("rst busy8", {31'd0, busy8}, 32'd0);
    chk("rst done1", {31'd0, done1}, 32'd0);
    chk("rst done8", {31'd0, done8}, 32'd0);
    clr_n = 1'b1;

    for (int i = 0; i < 16; i++) begin
      launch(vecs[i].op, vecs[i].a, vecs[i].amt);
      watch(vecs[i].name, vecs[i].res, vecs[i].l1, vecs[i].l8, 1'b0);
    end

    // Reset during RUN of ROR by 20: no done, registers cleared immediately.
    launch(OP_ROR, 32'h0000_00F1, 32'd20);
    @(negedge clk);
    chk("mid busy1 t0", {31'd0, busy1}, 32'd1);
    chk("mid done8 t0", {31'd0, done8}, 32'd0);
    @(negedge clk);
    chk("mid busy8 t1", {31'd0, busy8}, 32'd1);
    clr_n = 1'b0; #1;
    chk("mid rst result1", res1, 32'd0);
    chk("mid rst result8", res8, 32'd0);
    chk("mid rst busy1", {31'd0, busy1}, 32'd0);
    chk("mid rst busy8", {31'd0, busy8}, 32'd0);
    chk("mid rst done1", {31'd0, done1 | done8}, 32'd0);
    @(negedge clk);
    chk("mid rst hold done", {31'd0, done1 | done8}, 32'd0);
    clr_n = 1'b1;
    launch(OP_ROR, 32'h0000_00F1, 32'd4);
    watch("after rst", 32'h1000_000F, 4, 1, 1'b0);

    // start pulse during RUN must be ignored.
    launch(OP_SHR, 32'hFFFF_0000, 32'd16);
    watch("run pulse", 32'h0000_FFFF, 16, 2, 1'b1);

    // Back-to-back: start held through DONE is accepted with no IDLE cycle.
    start = 1'b1; op = OP_SHL; a = 32'h0000_0055; amount = 32'd0;
    @(posedge clk); #1;
    op = OP_ROL; a = 32'h8000_0000; amount = 32'd1;
    @(negedge clk);
    chk("b2b done1 first", {31'd0, done1}, 32'd1);
    chk("b2b done8 first", {31'd0, done8}, 32'd1);
    chk("b2b res1 first", res1, 32'h0000_0055);
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    chk("b2b busy1", {31'd0, busy1}, 32'd1);
    chk("b2b busy8", {31'd0, busy8}, 32'd1);
    chk("b2b done gap", {31'd0, done1 | done8}, 32'd0);
    @(negedge clk);
    chk("b2b done1 second", {31'd0, done1}, 32'd1);
    chk("b2b done8 second", {31'd0, done8}, 32'd1);
    chk("b2b res1 second", res1, 32'h0000_0001);
    chk("b2b res8 second", res8, 32'h0000_0001);
    @(negedge clk);
    chk("b2b done1 drop", {31'd0, done1}, 32'd0);
    chk("b2b res1 hold", res1, 32'h0000_0001);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
